fc_out_accumulator: RTL
=======================

# fc_out_accumulator

Final fully-connected stage of the CIFAR10 classifier. It accumulates a stream of input activations against ten parallel weight lanes, adds per-class biases, and presents the ten 27-bit class scores on a packed 270-bit bus with a one-cycle `valid` pulse. It sits directly upstream of the argmax comparator: `layer_out` and `valid` connect straight to the comparator's inputs of the same names.

## Interface
- `IN_WIDTH`, 8: signed activation width.
- `W_WIDTH`, 8: signed weight width.
- `BIAS_WIDTH`, 16: signed bias width.
- `ACC_WIDTH`, 27: per-class score width. Must match the comparator's `DATA_WIDTH`.
- `N_OUT`, 10: number of classes/lanes.
- `N_INPUTS`, 64: activations per frame. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `start`  in  1  frame start pulse; honoured only in IDLE.
- `in_valid`  in  1  activation beat valid.
- `in_data`  in  IN_WIDTH  signed activation.
- `weights`  in  N_OUT*W_WIDTH  signed weights for the current beat; lane k at [W_WIDTH*k +: W_WIDTH].
- `bias`  in  N_OUT*BIAS_WIDTH  signed biases; lane k at [BIAS_WIDTH*k +: BIAS_WIDTH]; sampled in the BIAS state.
- `in_ready`  out  1  high only in ACCUM.
- `busy`  out  1  high in every state except IDLE.
- `valid`  out  1  one-cycle pulse when `layer_out` is updated.
- `layer_out`  out  N_OUT*ACC_WIDTH  class scores; lane k at [ACC_WIDTH*k +: ACC_WIDTH].

## Operation
- **States:** IDLE → ACCUM → BIAS → DONE → IDLE.
- **IDLE**
  - `start`=1 clears all accumulators and the beat counter, then moves to ACCUM.
  - `in_valid` is ignored.
- **ACCUM**
  - `in_ready`=1.
  - Each beat with `in_valid && in_ready` does, for every lane k: acc_k ← acc_k + sext(in_data × w_k).
  - The product is a full 16-bit signed value, sign-extended to ACC_WIDTH.
  - The counter increments on each accepted beat. The beat that makes the count N_INPUTS moves to BIAS.
  - Gaps in `in_valid` stall the frame with no timeout.
- **BIAS**
  - One cycle: acc_k ← acc_k + sext(bias_k).
  - Moves to DONE.
- **DONE**
  - One cycle: `layer_out` ← packed accumulators, `valid`=1.
  - Moves to IDLE.
- **Arithmetic:** two's complement, wrapping modulo 2^ACC_WIDTH, no saturation. With the default parameters, overflow cannot occur: |sum| ≤ 64·2^14 + 2^15.
- **Output hold:** `layer_out` holds its value until the next DONE. The comparator registers its inputs and its `ready` lags by 2 cycles, so the bus must stay stable for at least 2 cycles after `valid`.
- **Ignored inputs:** `start` in ACCUM, BIAS or DONE is ignored; there is no restart. Beats presented outside ACCUM are not accepted.

## Timing
- **Reset:** `rst_n`=0 at a rising edge forces the following, regardless of state, including mid-frame:
  - state = IDLE
  - `in_ready`=0, `busy`=0, `valid`=0
  - `layer_out`=0
  - accumulators and counter = 0
- **Start:** `start` accepted at edge t gives `in_ready`=1 from t+1.
- **Latency:** the last beat accepted at edge t gives:
  - BIAS during cycle t+1
  - `valid`=1 and the new `layer_out` during cycle t+2
  - `busy`=0 from t+3
- **Throughput:** minimum frame length is N_INPUTS + 3 cycles including the start cycle. A back-to-back `start` is legal in the cycle after DONE.
- **Simultaneous `start` and `in_valid` in IDLE:** only `start` acts; that beat is not accepted.
- **`valid`:** never high for two consecutive cycles.

## Test plan
- **All ones:** start; 64 beats with x=1, all w=1, bias=0 → every lane 27'd64. `valid` 2 cycles after the 64th beat. `in_ready` drops right after the 64th beat.
- **Extremes:** x=−128 every beat; w0=−128, w1=127, other weights 0; bias=0 →
  - lane0 = 0x0100000
  - lane1 = 0x7F02000 (−1040384)
  - all other lanes 0
- **Bias sign-extension:** x=0 for all beats; bias_k = k−5 →
  - lane0 = 0x7FFFFFB
  - lane5 = 0
  - lane9 = 4
- **Stalls and overrun:** `in_valid` toggles every cycle, with `in_valid` still held high for 3 cycles past the 64th beat → result identical to the all-ones case. `valid` 2 cycles after the 64th accepted beat. Extra beats are not accepted.
- **Reset mid-frame:** `rst_n`=0 after 30 beats →
  - next cycle all outputs 0 and `busy`=0
  - a new all-ones frame then yields 64 per lane, with no carry-over
- **Start while busy:** `start` pulsed during ACCUM → beat count unaffected, single `valid`, correct result. `layer_out` stable until the following frame's DONE.

Source files
------------

// File: rtl/fc_out_accumulator_if.sv
// Handshake and result bus between the activation/weight source, the FC output accumulator and the argmax comparator.
interface fc_out_accumulator_if #(
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH  = 27,
  parameter int N_OUT      = 10
);
  logic                        start;
  logic                        in_valid;
  logic [IN_WIDTH-1:0]         in_data;
  logic [N_OUT*W_WIDTH-1:0]    weights;
  logic [N_OUT*BIAS_WIDTH-1:0] bias;
  logic                        in_ready;
  logic                        busy;
  logic                        valid;
  logic [N_OUT*ACC_WIDTH-1:0]  layer_out;

  modport master (
    output start, in_valid, in_data, weights, bias,
    input  in_ready, busy, valid, layer_out
  );

  modport slave (
    input  start, in_valid, in_data, weights, bias,
    output in_ready, busy, valid, layer_out
  );
endinterface

// File: rtl/fc_out_accumulator.sv
// Ten-lane MAC over N_INPUTS beats plus bias; valid pulses 2 cycles after the last beat.
// Beats are taken only while in_ready (ACCUM); layer_out holds until the next frame's result.
module fc_out_accumulator #(
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH  = 27,
  parameter int N_OUT      = 10,
  parameter int N_INPUTS   = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  fc_out_accumulator_if.slave bus
);
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = IN_WIDTH + W_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [ACC_WIDTH-1:0] acc      [N_OUT];
  logic [ACC_WIDTH-1:0] acc_beat [N_OUT];
  logic [ACC_WIDTH-1:0] acc_bias [N_OUT];

  // Full-width signed product and bias, both sign-extended into the accumulator width.
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic signed [PROD_W-1:0] prod;
    assign prod = PROD_W'($signed(bus.in_data)) *
                  PROD_W'($signed(bus.weights[W_WIDTH*k +: W_WIDTH]));
    assign acc_beat[k] = acc[k] + ACC_WIDTH'(prod);
    assign acc_bias[k] = acc[k] + ACC_WIDTH'($signed(bus.bias[BIAS_WIDTH*k +: BIAS_WIDTH]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      bus.in_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.valid     <= 1'b0;
      bus.layer_out <= '0;
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            count        <= '0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_valid && bus.in_ready) begin
            for (int k = 0; k < N_OUT; k++) acc[k] <= acc_beat[k];
            count <= count + CNT_W'(1);
            if (count == CNT_W'(N_INPUTS - 1)) begin
              bus.in_ready <= 1'b0;
              state        <= BIAS;
            end
          end
        end
        BIAS: begin
          // Publishing the biased sum here lets valid land in the DONE cycle.
          for (int k = 0; k < N_OUT; k++) begin
            acc[k]                                  <= acc_bias[k];
            bus.layer_out[ACC_WIDTH*k +: ACC_WIDTH] <= acc_bias[k];
          end
          bus.valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
